// File: rtl/msg_word_reader_if.sv
// Message-block reader bus bundle.
// Carries the message SRAM read port and the word stream towards the
// schedule/expansion logic.
//   master: the reader (drives SRAM requests and the word stream)
//   slave : the SRAM/downstream side (returns read data and word_ready)
interface msg_word_reader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              word_valid;
    logic              word_ready;
    logic [DATA_W-1:0] word_data;
    logic [IDX_W-1:0]  word_index;

    modport master (
        output mem_rd_en, mem_addr, word_valid, word_data, word_index,
        input  mem_rd_data, word_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, word_valid, word_data, word_index,
        output mem_rd_data, word_ready
    );
endinterface

// File: rtl/msg_word_reader.sv
// Reader side of the message-block handshake.
// On start, fetches NUM_WORDS words of one SHA-256 block from a synchronous
// single-port SRAM (one read in flight at a time) and presents them in order
// over a valid/ready stream, then pulses done.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   start      launch one block fetch (sampled only in IDLE)
//   base_addr  SRAM word address of word 0, latched on accepted start
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last word is accepted
//   bus        master side: mem_rd_en/mem_addr/mem_rd_data (SRAM),
//              word_valid/word_ready/word_data/word_index (word stream)
// Build option: define MSG_BYTE_SWAP_EN to byte-reverse each captured word
// (little-endian message SRAM; DATA_W must be 32). Timing is unchanged.
module msg_word_reader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    msg_word_reader_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;

    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] rd_word_c;

    // Word as it will be presented downstream.
`ifdef MSG_BYTE_SWAP_EN
    assign rd_word_c = {bus.mem_rd_data[7:0],   bus.mem_rd_data[15:8],
                        bus.mem_rd_data[23:16], bus.mem_rd_data[31:24]};
`else
    assign rd_word_c = bus.mem_rd_data;
`endif

    // Next state, latched base and word index.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        idx_nxt   = idx_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    base_nxt  = base_addr;
                    idx_nxt   = '0;
                    state_nxt = S_REQ;
                end
            end
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_OUT;
            S_OUT: begin
                if (valid_q && bus.word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_q + IDX_W'(1);
                        state_nxt = S_REQ;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, base and index registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            base_q <= '0;
            idx_q  <= '0;
        end else begin
            state  <= state_nxt;
            base_q <= base_nxt;
            idx_q  <= idx_nxt;
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with that state's cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= (state_nxt == S_REQ);
            if (state_nxt == S_REQ) begin
                // Address wraps modulo 2^ADDR_W.
                addr_q <= base_nxt + ADDR_W'(idx_nxt);
            end
            valid_q <= (state_nxt == S_OUT);
            // SRAM data is valid only during WAIT; held through OUT.
            if (state == S_WAIT) begin
                data_q  <= rd_word_c;
                index_q <= idx_q;
            end
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
        end
    end

    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_addr   = addr_q;
    assign bus.word_valid = valid_q;
    assign bus.word_data  = data_q;
    assign bus.word_index = index_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
